mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage between the execute stage and the write-back stage of the LoongArch32 five-stage core. It holds one instruction per cycle and waits for the data-SRAM response of a load issued in EX. It aligns and sign- or zero-extends the load data, forwards dest/result to the decode stage, and emits the MS-to-WS bus. A stale-response counter discards responses that belong to instructions flushed by an exception or ERTN.

Parameters:
none (bus widths come from shared macros: ES_TO_MS_BUS_WD=173, MS_TO_WS_BUS_WD=168)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
ms_allowin  out  1  MS can accept from EX this cycle
es_to_ms_valid  in  1  EX presents a valid instruction
es_to_ms_bus  in  173  {res_from_mem, mem_issued, ld_op[2:0], gr_we, dest[4:0], alu_result[31:0], pc[31:0], inst_no_dest, src_from_csr, csr_num[13:0], csr_we, csr_wdata[31:0], csr_wmask[31:0], ex, ex_code[14:0], ertn}
ws_allowin  in  1  WS can accept this cycle
ms_to_ws_valid  out  1  MS presents a finished instruction
ms_to_ws_bus  out  168  same field order as the es_to_ms_bus tail, with alu_result replaced by final_result
ms_to_ds_dest  out  5  forwarding dest; 0 when not writing
ms_to_ds_result  out  32  forwarding value (final_result)
ms_to_ds_blocked  out  1  dest matches but value not yet available; DS must stall
ms_ex_to_es  out  1  MS holds ex/ertn; EX must suppress new memory requests
data_sram_data_ok  in  1  one read/write response, returned in order
data_sram_rdata  in  32  read data, valid with data_ok
wb_ex  in  1  flush: exception at WS
wb_ertn_flush  in  1  flush: ERTN at WS

Behaviour:
- Reset: ms_valid=0, buf_valid=0, discard_cnt=0, bus register don't-care. Outputs: ms_to_ws_valid=0, ms_to_ds_dest=0, ms_to_ds_blocked=0, ms_ex_to_es=0, ms_allowin=1.
- flush = wb_ex | wb_ertn_flush.
- rsp_mine = data_sram_data_ok & (discard_cnt==0).
- ms_wait = ms_valid & mem_issued & ~ex.
- ms_ready_go = ~ms_wait | buf_valid | rsp_mine.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go & ~flush.
- Valid update:
  - flush: ms_valid<=0.
  - else if ms_allowin: ms_valid<=es_to_ms_valid.
  - The bus register loads when es_to_ms_valid & ms_allowin.
- Response buffer: when rsp_mine & ms_wait & ~buf_valid & ~(ws_allowin) & ~flush, capture rdata into data_buf and set buf_valid. Clear buf_valid when the instruction leaves (ms_to_ws_valid & ws_allowin) or on flush.
- Load data source: buf_valid ? data_buf : data_sram_rdata.
- Discard counter (2 bits), updated every cycle:
  - inc when flush & ms_wait & ~buf_valid & ~rsp_mine.
  - dec when data_sram_data_ok & discard_cnt!=0.
  - inc and dec together: value unchanged.
  - Never exceeds 2; reaching 3 is a design error, flagged by a simulation assertion.
- Load extraction uses addr = alu_result[1:0]:
  - LD_W (0): whole word.
  - LD_B (1) / LD_BU (3): byte addr, sign- or zero-extended.
  - LD_H (2) / LD_HU (4): half addr[1], sign- or zero-extended.
  - Other codes: whole word.
  - EX guarantees alignment; misaligned loads arrive as ex=1 with mem_issued=0.
- final_result = (res_from_mem & ~ex) ? load_data : alu_result. When ex=1, alu_result passes unchanged and serves as the bad virtual address.
- Stores with mem_issued=1 also wait for data_ok; their data is ignored.
- Forwarding:
  - ms_to_ds_dest = dest & {5{ms_valid & gr_we & ~inst_no_dest}}.
  - ms_to_ds_blocked = ms_valid & gr_we & ((res_from_mem & ~ms_ready_go) | src_from_csr).
- ms_ex_to_es = ms_valid & (ex | ertn).
- A reset during an outstanding load clears discard_cnt; the SRAM side is reset by the same signal.

Decomposition:
- mycpu_head.v gains ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, and LD_W/LD_B/LD_H/LD_BU/LD_HU encodings.
- One combinational sub-module, mem_load_align (inputs ld_op, addr[1:0], rdata[31:0]; output data[31:0]), reusable by a later cache path.

Test Plan:
- LD_B, alu_result=0x1000_0003, rdata=0x80AB_CDEF, data_ok in the same cycle -> final_result=0xFFFF_FF80, ms_to_ws_valid=1 that cycle.
- LD_HU, addr[1]=1, rdata=0x8001_7FFF, data_ok 3 cycles late -> blocked=1 and ms_allowin=0 for 3 cycles, then final_result=0x0000_8001.
- data_ok arrives while ws_allowin=0 for 2 cycles, then data_ok=0 -> buf_valid=1; after release, ws receives the buffered 0x1234_5678 once.
- Load waiting, wb_ex pulses -> next cycle ms_valid=0, discard_cnt=1. The next instruction's issued load: first data_ok (0xDEAD_BEEF) is dropped, second data_ok (0x0000_0042) is delivered.
- Flush in the same cycle as data_ok for the waiting load -> discard_cnt stays 0, instruction killed.
- ALE instruction (ex=1, ex_code=0x09, alu_result=0x2001) -> passes without waiting, ms_ex_to_es=1, final_result=0x2001.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load-op
// encodings and the packed layouts of the EX->MS and MS->WS buses.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 173;
    localparam int MS_TO_WS_BUS_WD = 168;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_H  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef struct packed {
        logic        res_from_mem;
        logic        mem_issued;
        logic [2:0]  ld_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
        logic        inst_no_dest;
        logic        src_from_csr;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wdata;
        logic [31:0] csr_wmask;
        logic        ex;
        logic [14:0] ex_code;
        logic        ertn;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
        logic        inst_no_dest;
        logic        src_from_csr;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wdata;
        logic [31:0] csr_wmask;
        logic        ex;
        logic [14:0] ex_code;
        logic        ertn;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the byte/half/word addressed by
// addr out of a 32-bit read word and sign- or zero-extends it.
// Ports: ld_op (load kind), addr (low address bits), rdata (raw word),
//        data (aligned, extended result).
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*addr +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (ld_op)
            LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data = {24'd0, byte_sel};
            LD_H:    data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Holds one instruction, waits for the
// data-SRAM response of a load/store issued in EX, aligns load data and
// forwards the result to DS and WS. Responses belonging to flushed
// instructions are dropped via a small discard counter.
// Ports: clk/reset; EX handshake (es_to_ms_valid, es_to_ms_bus, ms_allowin);
//        WS handshake (ms_to_ws_valid, ms_to_ws_bus, ws_allowin);
//        DS forwarding (ms_to_ds_dest/result/blocked); ms_ex_to_es;
//        SRAM response (data_sram_data_ok/rdata); flushes (wb_ex, wb_ertn_flush).
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [4:0]                 ms_to_ds_dest,
    output logic [31:0]                ms_to_ds_result,
    output logic                       ms_to_ds_blocked,
    output logic                       ms_ex_to_es,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       wb_ex,
    input  logic                       wb_ertn_flush
);

    logic        ms_valid;
    es_to_ms_t   ms_bus;
    logic        buf_valid;
    logic [31:0] data_buf;
    logic [1:0]  discard_cnt;

    logic        flush;
    logic        rsp_mine;
    logic        ms_wait;
    logic        ms_ready_go;
    logic        buf_capture;
    logic        cnt_inc;
    logic        cnt_dec;
    logic [31:0] raw_data;
    logic [31:0] load_data;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;

    assign flush       = wb_ex | wb_ertn_flush;
    // A response only belongs to us once every stale one has drained.
    assign rsp_mine    = data_sram_data_ok & (discard_cnt == 2'd0);
    assign ms_wait     = ms_valid & ms_bus.mem_issued & ~ms_bus.ex;
    assign ms_ready_go = ~ms_wait | buf_valid | rsp_mine;
    assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;

    // Response arrived but WS is stalled: hold it until the instruction leaves.
    assign buf_capture = rsp_mine & ms_wait & ~buf_valid & ~ws_allowin & ~flush;
    // Flushing a load whose response is still in flight leaves one stale response.
    assign cnt_inc     = flush & ms_wait & ~buf_valid & ~rsp_mine;
    assign cnt_dec     = data_sram_data_ok & (discard_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            ms_bus <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
        end else if (flush || (ms_to_ws_valid && ws_allowin)) begin
            buf_valid <= 1'b0;
        end else if (buf_capture) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_capture) begin
            data_buf <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= 2'd0;
        end else if (cnt_inc && !cnt_dec) begin
            discard_cnt <= discard_cnt + 2'd1;
        end else if (cnt_dec && !cnt_inc) begin
            discard_cnt <= discard_cnt - 2'd1;
        end
    end

    // At most two responses can ever be outstanding against this stage.
    assert property (@(posedge clk) disable iff (reset) discard_cnt != 2'd3);

    assign raw_data = buf_valid ? data_buf : data_sram_rdata;

    mem_load_align u_align (
        .ld_op (ms_bus.ld_op),
        .addr  (ms_bus.alu_result[1:0]),
        .rdata (raw_data),
        .data  (load_data)
    );

    // With ex set, alu_result carries the bad virtual address through.
    assign final_result = (ms_bus.res_from_mem & ~ms_bus.ex) ? load_data : ms_bus.alu_result;

    always_comb begin
        ws_bus.gr_we        = ms_bus.gr_we;
        ws_bus.dest         = ms_bus.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = ms_bus.pc;
        ws_bus.inst_no_dest = ms_bus.inst_no_dest;
        ws_bus.src_from_csr = ms_bus.src_from_csr;
        ws_bus.csr_num      = ms_bus.csr_num;
        ws_bus.csr_we       = ms_bus.csr_we;
        ws_bus.csr_wdata    = ms_bus.csr_wdata;
        ws_bus.csr_wmask    = ms_bus.csr_wmask;
        ws_bus.ex           = ms_bus.ex;
        ws_bus.ex_code      = ms_bus.ex_code;
        ws_bus.ertn         = ms_bus.ertn;
    end

    assign ms_to_ws_bus     = ws_bus;
    assign ms_to_ds_dest    = ms_bus.dest & {5{ms_valid & ms_bus.gr_we & ~ms_bus.inst_no_dest}};
    assign ms_to_ds_result  = final_result;
    assign ms_to_ds_blocked = ms_valid & ms_bus.gr_we &
                              ((ms_bus.res_from_mem & ~ms_ready_go) | ms_bus.src_from_csr);
    assign ms_ex_to_es      = ms_valid & (ms_bus.ex | ms_bus.ertn);

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [172:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [167:0] ms_to_ws_bus;
    logic [4:0]   ms_to_ds_dest;
    logic [31:0]  ms_to_ds_result;
    logic         ms_to_ds_blocked;
    logic         ms_ex_to_es;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         wb_ex;
    logic         wb_ertn_flush;

    int n_chk = 0;
    int n_bad = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_dest     (ms_to_ds_dest),
        .ms_to_ds_result   (ms_to_ds_result),
        .ms_to_ds_blocked  (ms_to_ds_blocked),
        .ms_ex_to_es       (ms_ex_to_es),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_ex             (wb_ex),
        .wb_ertn_flush     (wb_ertn_flush)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [167:0] got, input logic [167:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [172:0] mk_es(input logic rfm, input logic iss, input logic [2:0] op,
                                           input logic gwe, input logic [4:0] dst,
                                           input logic [31:0] alu, input logic [31:0] pc,
                                           input logic ex, input logic [14:0] code);
        return {rfm, iss, op, gwe, dst, alu, pc, 1'b0, 1'b0, 14'h123, 1'b0,
                32'hA5A5_A5A5, 32'h0F0F_0F0F, ex, code, 1'b0};
    endfunction

    function automatic logic [167:0] mk_ws(input logic gwe, input logic [4:0] dst,
                                           input logic [31:0] res, input logic [31:0] pc,
                                           input logic ex, input logic [14:0] code);
        return {gwe, dst, res, pc, 1'b0, 1'b0, 14'h123, 1'b0,
                32'hA5A5_A5A5, 32'h0F0F_0F0F, ex, code, 1'b0};
    endfunction

    // Inputs change 1ns after the rising edge; checks happen at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic send(input logic [172:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        tick();
        es_to_ms_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } align_vec_t;

    align_vec_t vecs[8];

    initial begin
        vecs[0] = '{LD_B,  2'd0, 32'h80AB_CDEF, 32'hFFFF_FFEF};
        vecs[1] = '{LD_BU, 2'd1, 32'h80AB_CDEF, 32'h0000_00CD};
        vecs[2] = '{LD_BU, 2'd2, 32'h80AB_CDEF, 32'h0000_00AB};
        vecs[3] = '{LD_H,  2'd0, 32'h80AB_CDEF, 32'hFFFF_CDEF};
        vecs[4] = '{LD_H,  2'd2, 32'h80AB_CDEF, 32'hFFFF_80AB};
        vecs[5] = '{LD_HU, 2'd0, 32'h80AB_CDEF, 32'h0000_CDEF};
        vecs[6] = '{LD_W,  2'd0, 32'h80AB_CDEF, 32'h80AB_CDEF};
        vecs[7] = '{3'd5,  2'd0, 32'h1357_9BDF, 32'h1357_9BDF};

        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        ws_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        wb_ex = 1'b0;
        wb_ertn_flush = 1'b0;
        tick();
        tick();
        settle();
        check_eq("rst_valid",   168'(ms_to_ws_valid), 168'(1'b0));
        check_eq("rst_dest",    168'(ms_to_ds_dest), 168'(5'd0));
        check_eq("rst_blocked", 168'(ms_to_ds_blocked), 168'(1'b0));
        check_eq("rst_ex",      168'(ms_ex_to_es), 168'(1'b0));
        check_eq("rst_allowin", 168'(ms_allowin), 168'(1'b1));
        tick();
        reset = 1'b0;

        // LD_B, response in the same cycle
        send(mk_es(1'b1, 1'b1, LD_B, 1'b1, 5'd3, 32'h1000_0003, 32'h1C00_0000, 1'b0, 15'd0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80AB_CDEF;
        settle();
        check_eq("ldb_valid",  168'(ms_to_ws_valid), 168'(1'b1));
        check_eq("ldb_result", 168'(ms_to_ds_result), 168'(32'hFFFF_FF80));
        check_eq("ldb_dest",   168'(ms_to_ds_dest), 168'(5'd3));
        check_eq("ldb_bus",    ms_to_ws_bus, mk_ws(1'b1, 5'd3, 32'hFFFF_FF80, 32'h1C00_0000, 1'b0, 15'd0));
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        check_eq("ldb_gone", 168'(ms_to_ws_valid), 168'(1'b0));

        // LD_HU, response three cycles late
        tick();
        send(mk_es(1'b1, 1'b1, LD_HU, 1'b1, 5'd7, 32'h1000_0002, 32'h1C00_0004, 1'b0, 15'd0));
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("ldhu_blocked", 168'(ms_to_ds_blocked), 168'(1'b1));
            check_eq("ldhu_allowin", 168'(ms_allowin), 168'(1'b0));
            check_eq("ldhu_wait",    168'(ms_to_ws_valid), 168'(1'b0));
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_7FFF;
        settle();
        check_eq("ldhu_valid",   168'(ms_to_ws_valid), 168'(1'b1));
        check_eq("ldhu_result",  168'(ms_to_ds_result), 168'(32'h0000_8001));
        check_eq("ldhu_unblock", 168'(ms_to_ds_blocked), 168'(1'b0));
        tick();
        data_sram_data_ok = 1'b0;

        // Response arrives while WS is stalled: buffered and delivered once
        send(mk_es(1'b1, 1'b1, LD_W, 1'b1, 5'd9, 32'h1000_0008, 32'h1C00_0008, 1'b0, 15'd0));
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        settle();
        check_eq("buf_allowin0", 168'(ms_allowin), 168'(1'b0));
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hFFFF_FFFF;
        settle();
        check_eq("buf_flag",   168'(dut.buf_valid), 168'(1'b1));
        check_eq("buf_valid",  168'(ms_to_ws_valid), 168'(1'b1));
        check_eq("buf_result", 168'(ms_to_ds_result), 168'(32'h1234_5678));
        tick();
        ws_allowin = 1'b1;
        settle();
        check_eq("buf_rel_valid",   168'(ms_to_ws_valid), 168'(1'b1));
        check_eq("buf_rel_result",  168'(ms_to_ds_result), 168'(32'h1234_5678));
        check_eq("buf_rel_allowin", 168'(ms_allowin), 168'(1'b1));
        tick();
        settle();
        check_eq("buf_once",  168'(ms_to_ws_valid), 168'(1'b0));
        check_eq("buf_clear", 168'(dut.buf_valid), 168'(1'b0));
        tick();

        // Flush while a load waits: its response must be discarded later
        send(mk_es(1'b1, 1'b1, LD_W, 1'b1, 5'd10, 32'h1000_000C, 32'h1C00_000C, 1'b0, 15'd0));
        wb_ex = 1'b1;
        settle();
        check_eq("fl_kill", 168'(ms_to_ws_valid), 168'(1'b0));
        tick();
        wb_ex = 1'b0;
        settle();
        check_eq("fl_cnt1",    168'(dut.discard_cnt), 168'(2'd1));
        check_eq("fl_allowin", 168'(ms_allowin), 168'(1'b1));
        send(mk_es(1'b1, 1'b1, LD_W, 1'b1, 5'd11, 32'h1000_0010, 32'h1C00_0010, 1'b0, 15'd0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        settle();
        check_eq("fl_drop_valid",   168'(ms_to_ws_valid), 168'(1'b0));
        check_eq("fl_drop_blocked", 168'(ms_to_ds_blocked), 168'(1'b1));
        tick();
        data_sram_rdata = 32'h0000_0042;
        settle();
        check_eq("fl_cnt0",   168'(dut.discard_cnt), 168'(2'd0));
        check_eq("fl_valid",  168'(ms_to_ws_valid), 168'(1'b1));
        check_eq("fl_result", 168'(ms_to_ds_result), 168'(32'h0000_0042));
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        check_eq("fl_gone", 168'(ms_to_ws_valid), 168'(1'b0));
        tick();

        // Flush in the same cycle as the waiting load's response
        send(mk_es(1'b1, 1'b1, LD_W, 1'b1, 5'd12, 32'h1000_0014, 32'h1C00_0014, 1'b0, 15'd0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_AAAA;
        wb_ertn_flush     = 1'b1;
        settle();
        check_eq("flok_kill", 168'(ms_to_ws_valid), 168'(1'b0));
        tick();
        data_sram_data_ok = 1'b0;
        wb_ertn_flush     = 1'b0;
        settle();
        check_eq("flok_cnt",   168'(dut.discard_cnt), 168'(2'd0));
        check_eq("flok_valid", 168'(ms_to_ws_valid), 168'(1'b0));
        tick();

        // ALE: exception instruction passes without waiting
        send(mk_es(1'b1, 1'b0, LD_W, 1'b1, 5'd4, 32'h0000_2001, 32'h1C00_0018, 1'b1, 15'h09));
        settle();
        check_eq("ale_valid",  168'(ms_to_ws_valid), 168'(1'b1));
        check_eq("ale_ex",     168'(ms_ex_to_es), 168'(1'b1));
        check_eq("ale_result", 168'(ms_to_ds_result), 168'(32'h0000_2001));
        check_eq("ale_bus",    ms_to_ws_bus, mk_ws(1'b1, 5'd4, 32'h0000_2001, 32'h1C00_0018, 1'b1, 15'h09));
        tick();
        settle();
        check_eq("ale_ex_gone", 168'(ms_ex_to_es), 168'(1'b0));
        tick();

        // Non-memory instruction passes alu_result straight through
        send(mk_es(1'b0, 1'b0, LD_W, 1'b1, 5'd6, 32'h0000_0055, 32'h1C00_001C, 1'b0, 15'd0));
        settle();
        check_eq("alu_valid",  168'(ms_to_ws_valid), 168'(1'b1));
        check_eq("alu_result", 168'(ms_to_ds_result), 168'(32'h0000_0055));
        tick();

        // Alignment table, each load answered in the cycle it arrives
        foreach (vecs[i]) begin
            send(mk_es(1'b1, 1'b1, vecs[i].op, 1'b1, 5'd8, {30'h0400_0000, vecs[i].addr},
                       32'h1C00_0100, 1'b0, 15'd0));
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = vecs[i].rdata;
            settle();
            check_eq($sformatf("align%0d", i), 168'(ms_to_ds_result), 168'(vecs[i].exp));
            tick();
            data_sram_data_ok = 1'b0;
        end

        // Reset while a stale response is outstanding clears the counter
        send(mk_es(1'b1, 1'b1, LD_W, 1'b1, 5'd13, 32'h1000_0020, 32'h1C00_0020, 1'b0, 15'd0));
        wb_ex = 1'b1;
        tick();
        wb_ex = 1'b0;
        settle();
        check_eq("rst_cnt1", 168'(dut.discard_cnt), 168'(2'd1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check_eq("rst_cnt0", 168'(dut.discard_cnt), 168'(2'd0));
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
